cga_text_pixel_sequencer: RTL and testbench
===========================================

Name: cga_text_pixel_sequencer

Overview:
- Downstream consumer of the CRTC timing stage in the CGA/MDA video path.
- Per character slot: latches the CRTC memory address, row address and controls, then fetches the character/attribute word from VRAM and looks up the font row.
- Serialises the font row as 8 pixels of 4-bit IRGB, aligned with delayed sync/blank outputs.
- Feeds the palette/scan-doubler stage.

Parameters:
- CHAR_W, 8, pixels per character cell; `pix_ce` pulses per `divclk` slot.
- BLINK_BIT, 4, bit of the frame counter used as the text blink phase.

Ports:
- clk  in  1  video master clock
- reset_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable
- divclk  in  1  character slot strobe; always coincides with a `pix_ce` pulse; slots are at least 4 clk apart
- mem_addr  in  14  CRTC character address
- row_addr  in  5  CRTC scanline within the row
- display_enable  in  1  CRTC active area
- cursor  in  1  CRTC cursor cell (already blink-gated)
- hsync_in  in  1  CRTC hsync
- vsync_in  in  1  CRTC vsync
- blink_en  in  1  1 = attr[7] is blink; 0 = attr[7] is background intensity
- vram_req  out  1  VRAM read request
- vram_addr  out  14  VRAM word address
- vram_ack  in  1  one-cycle ack; `vram_data` is valid on this cycle
- vram_data  in  16  [7:0] character, [15:8] attribute
- font_addr  out  11  {char[7:0], row[2:0]}
- font_data  in  8  font row, registered 1 clk after `font_addr`; MSB is the leftmost pixel
- pixel  out  4  IRGB colour index
- hsync_out, vsync_out, blank_out  out  1 each  syncs and blank aligned to `pixel`
- underrun  out  1  sticky: a fetch missed its slot

Behaviour:
- **Reset** (async, `reset_n` = 0). All of the following are cleared immediately:
  - outputs: `pixel`, `vram_req`, `vram_addr`, `font_addr`, `hsync_out`, `vsync_out`, `underrun`
  - internals: shift register, pipeline registers, frame counter, fetch FSM (to IDLE)
  - `blank_out` = 1
- **Slot capture** on `divclk`:
  - Latch A = {`mem_addr`, `row_addr`[2:0], `display_enable`, `cursor`, `hsync_in`, `vsync_in`}.
  - If `display_enable` = 1: next clk `vram_req` = 1 and `vram_addr` = `mem_addr`; FSM IDLE->REQ.
  - If `display_enable` = 0: no request is issued.
- **Fetch FSM** (IDLE, REQ, FONT, READY):
  - REQ: hold `vram_req` and `vram_addr` stable until `vram_ack`. On ack, latch char/attr, drive `font_addr` = {char, row[2:0]}, deassert `vram_req`, go to FONT.
  - FONT: next clk capture `font_data` into the next-cell buffer, go to READY.
  - READY: hold until `divclk`.
- **Cell load** on `divclk`:
  - The next-cell buffer (slot A contents: font bits, attr, cursor, de, syncs) loads into the output stage.
  - Slot-A capture for the new slot happens on the same clk.
  - Latency from slot capture to first pixel is exactly one character slot.
- **Missed fetch**: if `divclk` arrives while in REQ or FONT:
  - Load font bits = 0 and attr = 0x00 (pixel = 0).
  - Set `underrun` (sticky until reset).
  - Abort the old request; the new request is issued on the next clk.
- **Simultaneous ack and divclk**: counts as a miss. Data is discarded and `underrun` is set.
- **Shift**: on each `pix_ce`, shift the font register left by 1. The bit shifted out is pixel p.
- **Colour selection**:
  - fg = attr[3:0].
  - bg = {attr[7] & ~`blink_en`, attr[6:4]}.
  - Blink: if `blink_en` & attr[7] & frame_cnt[BLINK_BIT], fg is replaced by bg.
  - Cursor: if cursor = 1, every pixel of the cell is fg (unblinked).
  - `pixel` = p ? fg : bg, registered on `pix_ce`.
  - Blanked cell (de = 0): `pixel` = 0 and `blank_out` = 1.
- **Sync alignment**: `hsync_out`, `vsync_out` and `blank_out` update on cell load, from the delayed slot values. They change on the same clk as the cell's first pixel.
- **Frame counter**: 5-bit; increments on the rising edge of `vsync_in` (edge detected on clk); wraps 31->0.
- **Widths**: `font_addr` uses `row_addr`[2:0] only; `row_addr` bits [4:3] are ignored.

Test Plan:
- **Reset**: assert `reset_n` = 0 mid-REQ. Required: `vram_req` = 0, `pixel` = 0, `blank_out` = 1 with no clock edge; after release, FSM is IDLE.
- **Normal cell**:
  - Stimulus: `mem_addr` = 0x0123, row = 3, de = 1, `vram_data` = 0x1F41 with ack 2 clk after req, `font_data` = 0xC3.
  - Required: `vram_addr` = 0x0123 and `font_addr` = 0x20B.
  - Next slot outputs pixels 1,1,0,0,0,0,1,1 mapped to 0xF,0xF,0x1,0x1,0x1,0x1,0xF,0xF.
- **Blink**: attr 0x8F, `blink_en` = 1, drive 16 `vsync_in` pulses.
  - Required: set pixels switch from 0xF to 0x0 once frame_cnt[4] = 1.
  - With `blink_en` = 0, bg = 0x8 and fg stays 0xF.
- **Cursor**: `cursor` = 1, attr 0x07, `font_data` = 0x00. Required: all 8 pixels = 0x7.
- **Underrun**: withhold `vram_ack` past the next `divclk`. Required: that cell is 8 pixels of 0, `underrun` = 1 and stays 1; the following cell fetches normally.
- **Blank and sync alignment**: de = 0 with `hsync_in` = 1 in slot N. Required: no `vram_req`; in slot N+1, `blank_out` = 1, `hsync_out` = 1 and `pixel` = 0, all changing on the same clk.

Source files
------------

// File: rtl/cga_text_pixel_sequencer.sv
// Text-mode pixel sequencer: captures a CRTC slot, fetches char/attr and font row,
// then serialises the cell one slot later as IRGB pixels with aligned sync/blank.
module cga_text_pixel_sequencer #(
    parameter int CHAR_W    = 8,
    parameter int BLINK_BIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_ce,
    input  logic              divclk,
    input  logic [13:0]       mem_addr,
    input  logic [4:0]        row_addr,
    input  logic              display_enable,
    input  logic              cursor,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blink_en,
    output logic              vram_req,
    output logic [13:0]       vram_addr,
    input  logic              vram_ack,
    input  logic [15:0]       vram_data,
    output logic [10:0]       font_addr,
    input  logic [CHAR_W-1:0] font_data,
    output logic [3:0]        pixel,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_out,
    output logic              underrun,
    output logic [1:0]        fetch_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FONT = 2'd2, READY = 2'd3} state_t;

    state_t            state, state_nx;
    logic [13:0]       a_addr;
    logic [2:0]        a_row;
    logic              a_de, a_cur, a_hs, a_vs;
    logic [7:0]        char_q, attr_q, o_attr;
    logic [CHAR_W-1:0] nb_font, sh, load_font;
    logic [7:0]        load_attr;
    logic              o_cur, o_de, miss, vs_d;
    logic [4:0]        frame_cnt;
    logic              row_hi_unused;

    assign row_hi_unused = ^row_addr[4:3];
    assign miss          = divclk && (state == REQ || state == FONT);
    assign load_font     = (state == READY) ? nb_font : '0;
    assign load_attr     = (state == READY) ? attr_q : 8'h00;
    assign vram_addr     = a_addr;

    function automatic logic [3:0] colour(input logic on, input logic [7:0] attr,
                                          input logic cur, input logic de,
                                          input logic blink_ph, input logic blink_on);
        logic [3:0] fg_raw, bg, fg;
        fg_raw = attr[3:0];
        bg     = {attr[7] & ~blink_on, attr[6:4]};
        fg     = (blink_on && attr[7] && blink_ph) ? bg : fg_raw;
        if (!de)      return 4'h0;
        else if (cur) return fg_raw;
        else          return on ? fg : bg;
    endfunction

    // VRAM handshake: vram_req stays high with vram_addr stable until a one-cycle
    // vram_ack; vram_data is only valid on the ack cycle. A new divclk aborts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (divclk) begin
            state_nx = display_enable ? REQ : IDLE;
        end else begin
            case (state)
                REQ:     if (vram_ack) state_nx = FONT;
                FONT:    state_nx = READY;
                default: state_nx = state;
            endcase
        end
    end

    // font_addr goes out on the ack cycle so the registered font ROM answers in FONT.
    always_comb begin
        vram_req    = (state == REQ);
        fetch_state = state;
        font_addr   = {char_q, a_row};
        if (state == REQ && vram_ack) font_addr = {vram_data[7:0], a_row};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_addr  <= '0;
            a_row   <= '0;
            a_de    <= 1'b0;
            a_cur   <= 1'b0;
            a_hs    <= 1'b0;
            a_vs    <= 1'b0;
            char_q  <= '0;
            attr_q  <= '0;
            nb_font <= '0;
        end else begin
            if (divclk) begin
                a_addr <= mem_addr;
                a_row  <= row_addr[2:0];
                a_de   <= display_enable;
                a_cur  <= cursor;
                a_hs   <= hsync_in;
                a_vs   <= vsync_in;
            end else begin
                if (state == REQ && vram_ack) begin
                    char_q <= vram_data[7:0];
                    attr_q <= vram_data[15:8];
                end
                if (state == FONT) nb_font <= font_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh        <= '0;
            o_attr    <= '0;
            o_cur     <= 1'b0;
            o_de      <= 1'b0;
            pixel     <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b1;
            underrun  <= 1'b0;
        end else if (divclk) begin
            // Cell load: first pixel, syncs and blank all change on this clk.
            sh        <= {load_font[CHAR_W-2:0], 1'b0};
            o_attr    <= load_attr;
            o_cur     <= a_cur;
            o_de      <= a_de;
            pixel     <= colour(load_font[CHAR_W-1], load_attr, a_cur, a_de,
                                frame_cnt[BLINK_BIT], blink_en);
            hsync_out <= a_hs;
            vsync_out <= a_vs;
            blank_out <= ~a_de;
            if (miss) underrun <= 1'b1;
        end else if (pix_ce) begin
            sh    <= {sh[CHAR_W-2:0], 1'b0};
            pixel <= colour(sh[CHAR_W-1], o_attr, o_cur, o_de, frame_cnt[BLINK_BIT], blink_en);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_d      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_d <= vsync_in;
            if (vsync_in && !vs_d) frame_cnt <= frame_cnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_cga_text_pixel_sequencer.sv
// Directed bench for cga_text_pixel_sequencer: one 8-clk slot per task call,
// pix_ce held high, VRAM ack and font ROM modelled locally.
module tb_cga_text_pixel_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_ce, divclk;
    logic [13:0] mem_addr;
    logic [4:0]  row_addr;
    logic        display_enable, cursor, hsync_in, vsync_in, blink_en;
    logic        vram_req, vram_ack;
    logic [13:0] vram_addr;
    logic [15:0] vram_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic [3:0]  pixel;
    logic        hsync_out, vsync_out, blank_out, underrun;
    logic [1:0]  fetch_state;

    int checks   = 0;
    int failures = 0;

    logic [10:0] rom_match;
    logic [7:0]  font_row;
    logic [3:0]  pix_log[8];
    logic        blank_log[8], hs_log[8], req_log[8], und_log[8];
    logic [13:0] addr_log[8];
    logic [10:0] fa_log[8];
    logic [1:0]  st_log[8];

    cga_text_pixel_sequencer #(.CHAR_W(8), .BLINK_BIT(4)) dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .divclk(divclk),
        .mem_addr(mem_addr), .row_addr(row_addr), .display_enable(display_enable),
        .cursor(cursor), .hsync_in(hsync_in), .vsync_in(vsync_in), .blink_en(blink_en),
        .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
        .vram_data(vram_data), .font_addr(font_addr), .font_data(font_data),
        .pixel(pixel), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .blank_out(blank_out), .underrun(underrun), .fetch_state(fetch_state)
    );

    always #5 clk = ~clk;

    // Registered font ROM: answers only for the address the current slot should use.
    always @(posedge clk) font_data <= (font_addr == rom_match) ? font_row : 8'hA5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_cell(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_pix%0d", tag, i), {28'd0, pix_log[i]}, {28'd0, exp[31-4*i -: 4]});
    endtask

    // One character slot: divclk on the first edge, ack raised after edge ack_dly
    // (sampled on the following edge; -1 = never). Logs outputs after each edge.
    task automatic slot(input logic [13:0] ma, input logic [4:0] ra, input logic de,
                        input logic cur, input logic hs, input int ack_dly,
                        input logic [15:0] vd, input logic [7:0] fr);
        mem_addr       = ma;
        row_addr       = ra;
        display_enable = de;
        cursor         = cur;
        hsync_in       = hs;
        vram_data      = vd;
        font_row       = fr;
        rom_match      = {vd[7:0], ra[2:0]};
        divclk         = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) divclk = 1'b0;
            vram_ack     = (c == ack_dly);
            pix_log[c]   = pixel;
            blank_log[c] = blank_out;
            hs_log[c]    = hsync_out;
            req_log[c]   = vram_req;
            und_log[c]   = underrun;
            addr_log[c]  = vram_addr;
            fa_log[c]    = font_addr;
            st_log[c]    = fetch_state;
        end
    endtask

    initial begin
        reset_n = 1'b0; pix_ce = 1'b1; divclk = 1'b0; mem_addr = '0; row_addr = '0;
        display_enable = 1'b0; cursor = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        blink_en = 1'b1; vram_ack = 1'b0; vram_data = '0; rom_match = '0; font_row = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel", {28'd0, pixel}, 32'h0);
        check("rst_blank", {31'd0, blank_out}, 32'h1);
        check("rst_req", {31'd0, vram_req}, 32'h0);
        check("rst_hsync", {31'd0, hsync_out}, 32'h0);
        check("rst_underrun", {31'd0, underrun}, 32'h0);
        check("rst_state", {30'd0, fetch_state}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal cell: addr 0x0123 row 3, char 0x41 attr 0x1F, font 0xC3
        slot(14'h0123, 5'd3, 1'b1, 1'b0, 1'b0, 2, 16'h1F41, 8'hC3);
        check("s1_req", {31'd0, req_log[0]}, 32'h1);
        check("s1_addr", {18'd0, addr_log[0]}, 32'h0123);
        check("s1_req_hold", {31'd0, req_log[2]}, 32'h1);
        check("s1_addr_hold", {18'd0, addr_log[2]}, 32'h0123);
        check("s1_req_drop", {31'd0, req_log[4]}, 32'h0);
        check("s1_font_addr", {21'd0, fa_log[4]}, 32'h020B);
        check("s1_ready", {30'd0, st_log[5]}, 32'h3);

        // Blink cells (attr 0x8F, font 0xF0), frame counter still 0
        slot(14'h0200, 5'd1, 1'b1, 1'b0, 1'b0, 2, 16'h8F20, 8'hF0);
        check_cell("normal", 32'hFF1111FF);
        check("normal_blank", {31'd0, blank_log[0]}, 32'h0);
        slot(14'h0201, 5'd1, 1'b1, 1'b0, 1'b0, 2, 16'h8F20, 8'hF0);
        check_cell("blink_off_phase", 32'hFFFF0000);

        for (int i = 0; i < 16; i++) begin
            vsync_in = 1'b1;
            @(posedge clk);
            #1;
            vsync_in = 1'b0;
            @(posedge clk);
            #1;
        end
        slot(14'h0202, 5'd1, 1'b1, 1'b0, 1'b0, 2, 16'h8F20, 8'hF0);
        check_cell("blink_on_phase", 32'h00000000);

        // Cursor cell, attr 0x07 font 0x00; logs the last blink cell with blink_en=0
        blink_en = 1'b0;
        slot(14'h0300, 5'b11101, 1'b1, 1'b1, 1'b0, 2, 16'h0711, 8'h00);
        check_cell("intensity_bg", 32'hFFFF8888);

        // Slot N: blanked with hsync high
        slot(14'h0310, 5'd0, 1'b0, 1'b0, 1'b1, -1, 16'h0000, 8'h00);
        check_cell("cursor", 32'h77777777);
        check("blank_no_req", {31'd0, req_log[0]}, 32'h0);
        check("pre_blank", {31'd0, blank_log[7]}, 32'h0);
        check("pre_hsync", {31'd0, hs_log[7]}, 32'h0);

        // Slot N+1 shows the blanked cell
        slot(14'h0400, 5'd2, 1'b1, 1'b0, 1'b0, 2, 16'h2E55, 8'h81);
        check("blank_edge", {31'd0, blank_log[0]}, 32'h1);
        check("hsync_edge", {31'd0, hs_log[0]}, 32'h1);
        check_cell("blanked", 32'h00000000);
        check("no_underrun", {31'd0, und_log[7]}, 32'h0);

        // Ack on the same clk as divclk counts as a miss
        slot(14'h0500, 5'd4, 1'b1, 1'b0, 1'b0, 7, 16'h1F66, 8'hFF);
        check_cell("attr2e", 32'hE222222E);
        check("pre_miss_underrun", {31'd0, und_log[7]}, 32'h0);

        // Ack withheld across the next divclk
        slot(14'h0600, 5'd3, 1'b1, 1'b0, 1'b0, -1, 16'h1F41, 8'hC3);
        check("sim_ack_underrun", {31'd0, und_log[0]}, 32'h1);
        check_cell("sim_ack_cell", 32'h00000000);

        slot(14'h0700, 5'b11011, 1'b1, 1'b0, 1'b0, 2, 16'h1F41, 8'hC3);
        check_cell("withheld_cell", 32'h00000000);
        check("underrun_sticky", {31'd0, und_log[0]}, 32'h1);
        check("refetch_req", {31'd0, req_log[0]}, 32'h1);
        check("refetch_addr", {18'd0, addr_log[0]}, 32'h0700);
        check("row_hi_ignored", {21'd0, fa_log[4]}, 32'h020B);

        slot(14'h0800, 5'd3, 1'b1, 1'b0, 1'b0, 2, 16'h1F41, 8'hC3);
        check_cell("recovered", 32'hFF1111FF);
        check("underrun_held", {31'd0, und_log[7]}, 32'h1);

        // Async reset in the middle of a request
        mem_addr = 14'h0900; row_addr = 5'd3; display_enable = 1'b1; divclk = 1'b1;
        @(posedge clk);
        #1;
        divclk = 1'b0;
        check("mid_req_state", {30'd0, fetch_state}, 32'h1);
        check("mid_req_pixel", {28'd0, pixel}, 32'hF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_req", {31'd0, vram_req}, 32'h0);
        check("async_pixel", {28'd0, pixel}, 32'h0);
        check("async_blank", {31'd0, blank_out}, 32'h1);
        check("async_underrun", {31'd0, underrun}, 32'h0);
        check("async_vram_addr", {18'd0, vram_addr}, 32'h0);
        check("async_font_addr", {21'd0, font_addr}, 32'h0);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_state", {30'd0, fetch_state}, 32'h0);
        check("post_rst_req", {31'd0, vram_req}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
